data_bus_port: RTL and testbench

- Parametrised per-module attachment to the shared crypto-interconnect bus. Second generation of the module bus interface.
- Sender side: requests the bus from a central arbiter, then drives one packet (header beat plus payload beats) onto tri-state lines, with explicit last-beat framing.
- Receiver side: snoops every packet, decodes src/dest from the header, and buffers matching beats in a local RX FIFO. It back-pressures the owner through a wired-OR stall line when that FIFO is full.

---
 rtl/data_bus_port.sv | 171 +++++++++++++++++
 tb/tb_data_bus_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_port.sv
// Per-module attachment to the shared crypto-interconnect bus: it arbitrates for and drives
// whole packets onto the tri-state lines, and snoops every packet into a local RX FIFO.
module data_bus_port #(
    parameter int DATA_W   = 8,
    parameter int ID_W     = 2,
    parameter int CTRL_ID  = 2**ID_W - 1,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   my_id,
    input  logic              send_valid,
    input  logic [DATA_W-1:0] send_data,
    input  logic              send_last,
    output logic              send_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              recv_valid,
    output logic [DATA_W-1:0] recv_data,
    output logic              recv_first,
    output logic              recv_last,
    input  logic              recv_ready,
    output logic [7:0]        rx_pkt_cnt,
    inout  wire  [DATA_W-1:0] bus_data,
    inout  wire               bus_valid,
    inout  wire               bus_last,
    inout  wire               bus_stall
);

    localparam int PTR_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RX_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [ID_W-1:0]  CTRL_ID_V = ID_W'(CTRL_ID);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OWN
    } state_t;

    state_t             r_state;
    logic               r_bus_req;
    logic               r_in_pkt;
    logic [ID_W-1:0]    r_dest;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_pkt_cnt;
    logic [ENTRY_W-1:0] r_mem [RX_DEPTH];

    logic               w_own;
    logic               w_send_xfer;
    logic               w_bus_xfer;
    logic [ID_W-1:0]    w_hdr_dest;
    logic [ID_W-1:0]    w_dest;
    logic               w_match;
    logic               w_full;
    logic               w_empty;
    logic               w_stall;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    // ---------------- sender ----------------
    assign w_own       = (r_state == S_OWN);
    assign send_ready  = w_own && !bus_stall;
    assign w_send_xfer = send_valid && send_ready;
    assign bus_req     = r_bus_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (send_valid) begin
                        r_state   <= S_REQ;
                        r_bus_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    // Losing the grant here is an arbiter fault; ownership is kept until last beat.
                    if (w_send_xfer && send_last) begin
                        r_state   <= S_IDLE;
                        r_bus_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data  = w_own ? send_data  : {DATA_W{1'bz}};
    assign bus_valid = w_own ? send_valid : 1'bz;
    assign bus_last  = w_own ? send_last  : 1'bz;

    // ---------------- receiver ----------------
    assign w_bus_xfer = bus_valid && !bus_stall;
    assign w_hdr_dest = bus_data[2+2*ID_W-1:2+ID_W];
    assign w_dest     = r_in_pkt ? r_dest : w_hdr_dest;
    assign w_match    = (my_id == w_dest) || (my_id == CTRL_ID_V);
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_stall    = bus_valid && w_match && w_full;
    assign w_push     = w_bus_xfer && w_match;
    assign w_pop      = recv_ready && !w_empty;

    // Wired-OR: only ever pull high, otherwise leave the line to the bus pull-down.
    assign bus_stall = w_stall ? 1'b1 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_pkt <= 1'b0;
            r_dest   <= '0;
        end else if (w_bus_xfer) begin
            r_in_pkt <= !bus_last;
            if (!r_in_pkt) begin
                r_dest <= w_hdr_dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {!r_in_pkt, bus_last, bus_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pkt_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && bus_last) begin
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end
        end
    end

    // Head outputs are forced to zero while empty so stale storage never leaks out.
    assign w_head     = r_mem[r_rd_ptr];
    assign recv_valid = !w_empty;
    assign recv_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign recv_first = !w_empty && w_head[DATA_W+1];
    assign recv_last  = !w_empty && w_head[DATA_W];
    assign rx_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_data_bus_port.sv
// Four ports (IDs 0..3, ID 3 = controller) share one bus with a simple bench arbiter;
// directed packets check sending, snooping, stall back-pressure, reset and counter wrap.
module tb_data_bus_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send_valid [4];
    logic [7:0] send_data  [4];
    logic       send_last  [4];
    logic       send_ready [4];
    logic       bus_req    [4];
    logic       gnt        [4];
    logic [1:0] req_age    [4];
    logic       recv_valid [4];
    logic [7:0] recv_data  [4];
    logic       recv_first [4];
    logic       recv_last  [4];
    logic       recv_ready [4];
    logic [7:0] rx_pkt_cnt [4];

    wire  [7:0] bus_data;
    wire        bus_valid;
    wire        bus_last;
    wire        bus_stall;

    pullup   (bus_data);
    pulldown (bus_valid);
    pulldown (bus_last);
    pulldown (bus_stall);

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_port
        data_bus_port #(
            .DATA_W   (8),
            .ID_W     (2),
            .CTRL_ID  (3),
            .RX_DEPTH (4)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .my_id      (2'(gi)),
            .send_valid (send_valid[gi]),
            .send_data  (send_data[gi]),
            .send_last  (send_last[gi]),
            .send_ready (send_ready[gi]),
            .bus_req    (bus_req[gi]),
            .bus_gnt    (gnt[gi]),
            .recv_valid (recv_valid[gi]),
            .recv_data  (recv_data[gi]),
            .recv_first (recv_first[gi]),
            .recv_last  (recv_last[gi]),
            .recv_ready (recv_ready[gi]),
            .rx_pkt_cnt (rx_pkt_cnt[gi]),
            .bus_data   (bus_data),
            .bus_valid  (bus_valid),
            .bus_last   (bus_last),
            .bus_stall  (bus_stall)
        );
    end

    // Grant follows a held request by two cycles and stays up until the request drops.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || !bus_req[k]) begin
                req_age[k] <= 2'd0;
                gnt[k]     <= 1'b0;
            end else begin
                if (req_age[k] != 2'd3) req_age[k] <= req_age[k] + 2'd1;
                gnt[k] <= (req_age[k] >= 2'd1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        else n_pass++;
    endtask

    // Drive one beat from port k and return on the negedge after it was taken.
    task automatic send_beat(input int k, input logic [7:0] d, input logic l);
        int waited = 0;
        send_valid[k] = 1'b1;
        send_data[k]  = d;
        send_last[k]  = l;
        #1;
        while (!send_ready[k] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!send_ready[k]) chk("send_ready_timeout", send_ready[k], 1);
        @(negedge clk);
        send_valid[k] = 1'b0;
        $display("tx port %0d data %02h last %0d", k, d, l);
    endtask

    task automatic pop_check(input int k, input logic f, input logic l, input logic [7:0] d);
        #1;
        chk("rx_valid", recv_valid[k], 1);
        chk("rx_first", recv_first[k], f);
        chk("rx_last",  recv_last[k],  l);
        chk("rx_data",  recv_data[k],  d);
        recv_ready[k] = 1'b1;
        @(negedge clk);
        recv_ready[k] = 1'b0;
        $display("rx port %0d data %02h first %0d last %0d", k, d, f, l);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] stall_tail [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            send_valid[k] = 1'b0;
            send_data[k]  = 8'h00;
            send_last[k]  = 1'b0;
            recv_ready[k] = 1'b0;
        end
        stall_tail[0] = 8'h02;
        stall_tail[1] = 8'h03;
        stall_tail[2] = 8'h04;
        stall_tail[3] = 8'h05;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req",       bus_req[1],    0);
        chk("rst_ready",     send_ready[1], 0);
        chk("rst_rx_valid",  recv_valid[3], 0);
        chk("rst_rx_data",   recv_data[3],  0);
        chk("rst_pkt_cnt",   rx_pkt_cnt[2], 0);
        chk("rst_bus_float", bus_data,      8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Port 1 sends header 0x28 (dest 2) + 2 payload beats, cycle by cycle.
        send_valid[1] = 1'b1;
        send_data[1]  = 8'h28;
        send_last[1]  = 1'b0;
        #1;
        chk("t1_req_idle", bus_req[1], 0);
        @(negedge clk); #1;
        chk("t1_req_up",   bus_req[1],    1);
        chk("t1_rdy_req",  send_ready[1], 0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t1_rdy_wait", send_ready[1], 0);
        @(negedge clk); #1;
        chk("t1_rdy_own",  send_ready[1], 1);
        chk("t1_hdr_bus",  bus_data,      8'h28);
        chk("t1_hdr_vld",  bus_valid,     1);
        @(negedge clk);
        send_data[1] = 8'h11;
        #1;
        chk("t1_b1_bus", bus_data, 8'h11);
        chk("t1_b1_rdy", send_ready[1], 1);
        @(negedge clk);
        send_data[1] = 8'h22;
        send_last[1] = 1'b1;
        #1;
        chk("t1_b2_bus",  bus_data, 8'h22);
        chk("t1_b2_last", bus_last, 1);
        @(negedge clk);
        send_valid[1] = 1'b0;
        send_last[1]  = 1'b0;
        #1;
        chk("t1_rel_req",  bus_req[1],    0);
        chk("t1_rel_data", bus_data,      8'hFF);
        chk("t1_rel_rdy",  send_ready[1], 0);
        chk("t1_p0_none",  recv_valid[0], 0);
        chk("t1_p1_none",  recv_valid[1], 0);
        chk("t1_p2_cnt",   rx_pkt_cnt[2], 1);
        for (int p = 2; p < 4; p++) begin
            pop_check(p, 1, 0, 8'h28);
            pop_check(p, 0, 0, 8'h11);
            pop_check(p, 0, 1, 8'h22);
        end

        // Header 0x24 (src 1, dest 2) + 2 payload beats.
        send_beat(1, 8'h24, 0);
        send_beat(1, 8'hA5, 0);
        send_beat(1, 8'h5A, 1);
        #1;
        chk("t2_p0_none", recv_valid[0], 0);
        chk("t2_p2_cnt",  rx_pkt_cnt[2], 2);
        chk("t2_p3_cnt",  rx_pkt_cnt[3], 2);
        for (int p = 2; p < 4; p++) begin
            pop_check(p, 1, 0, 8'h24);
            pop_check(p, 0, 0, 8'hA5);
            pop_check(p, 0, 1, 8'h5A);
        end

        // 6-beat packet into full FIFOs (ports 2 and 3 both match).
        send_beat(1, 8'h28, 0);
        send_beat(1, 8'h01, 0);
        send_beat(1, 8'h02, 0);
        send_beat(1, 8'h03, 0);
        send_valid[1] = 1'b1;
        send_data[1]  = 8'h04;
        send_last[1]  = 1'b0;
        #1;
        chk("t3_stall",     bus_stall,     1);
        chk("t3_rdy_stall", send_ready[1], 0);
        @(negedge clk); #1;
        chk("t3_hold_data", bus_data,  8'h04);
        chk("t3_hold_stall", bus_stall, 1);
        pop_check(2, 1, 0, 8'h28);
        recv_ready[3] = 1'b1;
        #1;
        chk("t3_pop_same_cyc", bus_stall, 1);
        chk("t3_p3_head",      recv_data[3], 8'h28);
        @(negedge clk);
        recv_ready[3] = 1'b0;
        #1;
        chk("t3_unstall",  bus_stall,     0);
        chk("t3_rdy_back", send_ready[1], 1);
        @(negedge clk);
        send_data[1] = 8'h05;
        send_last[1] = 1'b1;
        #1;
        chk("t3_refull", bus_stall, 1);
        pop_check(2, 0, 0, 8'h01);
        pop_check(3, 0, 0, 8'h01);
        #1;
        chk("t3_last_rdy", send_ready[1], 1);
        @(negedge clk);
        send_valid[1] = 1'b0;
        send_last[1]  = 1'b0;
        #1;
        chk("t3_rel_req", bus_req[1],    0);
        chk("t3_p2_cnt",  rx_pkt_cnt[2], 3);
        for (int p = 2; p < 4; p++) begin
            for (int i = 0; i < 4; i++) pop_check(p, 0, (i == 3), stall_tail[i]);
        end

        // Single-beat packet, header 0x08 (dest 0).
        send_beat(1, 8'h08, 1);
        #1;
        chk("t4_p0_cnt",  rx_pkt_cnt[0], 1);
        chk("t4_p3_cnt",  rx_pkt_cnt[3], 4);
        chk("t4_p2_none", recv_valid[2], 0);
        pop_check(0, 1, 1, 8'h08);
        pop_check(3, 1, 1, 8'h08);

        // Reset while port 1 owns the bus mid-packet.
        send_beat(1, 8'h28, 0);
        send_valid[1] = 1'b1;
        send_data[1]  = 8'h11;
        #1;
        chk("t5_pre_own", bus_data, 8'h11);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req",   bus_req[1],    0);
        chk("t5_rst_data",  bus_data,      8'hFF);
        chk("t5_rst_rdy",   send_ready[1], 0);
        chk("t5_rst_p2",    recv_valid[2], 0);
        chk("t5_rst_p3",    recv_valid[3], 0);
        chk("t5_rst_first", recv_first[3], 0);
        chk("t5_rst_cnt",   rx_pkt_cnt[3], 0);
        send_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(1, 8'h08, 1);
        #1;
        chk("t5_p2_none", recv_valid[2], 0);
        pop_check(0, 1, 1, 8'h08);

        // 256 single-beat packets to port 0: counter wraps back to 0.
        do_reset();
        recv_ready[0] = 1'b1;
        recv_ready[3] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_beat(1, 8'h08, 1);
            if (i == 254) begin
                #1;
                chk("t6_cnt_255", rx_pkt_cnt[0], 255);
            end
        end
        #1;
        chk("t6_wrap_p0", rx_pkt_cnt[0], 0);
        chk("t6_wrap_p3", rx_pkt_cnt[3], 0);
        recv_ready[0] = 1'b0;
        recv_ready[3] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
